sim_exit_monitor: RTL and testbench

//  Simulation-side consumer of the SoC exit interface (exit_valid/exit_value) and UART activity.

---
 rtl/sim_exit_monitor_pkg.sv | 16 +
 rtl/sim_exit_monitor_if.sv | 22 ++
 rtl/sim_exit_monitor_filter.sv | 49 ++++
 rtl/sim_exit_monitor.sv | 133 +++++++++++++
 tb/tb_sim_exit_monitor.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sim_exit_monitor_pkg.sv
// Shared types and constants for the simulation exit monitor.
// State encoding, exit code type and the watchdog exit code.
package sim_exit_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } exit_mon_state_e;

    typedef logic [31:0] exit_code_t;

    localparam exit_code_t TIMEOUT_CODE = 32'hFFFF_FFFF;

endpackage

// File: rtl/sim_exit_monitor_if.sv
// SoC exit request and UART heartbeat bundle.
// The SoC side drives it (master); the monitor samples it (slave).
interface sim_exit_monitor_if;
    import sim_exit_monitor_pkg::*;

    logic       exit_valid_i;
    exit_code_t exit_value_i;
    logic       activity_i;

    modport master (
        output exit_valid_i,
        output exit_value_i,
        output activity_i
    );

    modport slave (
        input exit_valid_i,
        input exit_value_i,
        input activity_i
    );

endinterface

// File: rtl/sim_exit_monitor_filter.sv
// Exit request qualifier: accepts a value held valid and unchanged
// for STABLE_CYCLES sampled cycles. Cleared whenever i_en is low.
module sim_exit_filter
    import sim_exit_monitor_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       i_en,
    input  logic       i_valid,
    input  exit_code_t i_value,
    output logic       o_accept,
    output exit_code_t o_value
);

    logic [31:0] r_stab;
    exit_code_t  r_val;
    logic [31:0] w_stab_nxt;
    exit_code_t  w_val_nxt;

    always_comb begin
        w_stab_nxt = r_stab;
        w_val_nxt  = r_val;
        if (!i_valid) begin
            w_stab_nxt = '0;
        end else if (r_stab == '0 || i_value != r_val) begin
            w_val_nxt  = i_value;
            w_stab_nxt = 32'd1;
        end else if (r_stab != '1) begin
            w_stab_nxt = r_stab + 32'd1;
        end
    end

    // Accept fires on the edge where the count would reach the target.
    assign o_accept = i_en && i_valid && (w_stab_nxt == STABLE_CYCLES);
    assign o_value  = w_val_nxt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || !i_en) begin
            r_stab <= '0;
            r_val  <= '0;
        end else begin
            r_stab <= w_stab_nxt;
            r_val  <= w_val_nxt;
        end
    end

endmodule

// File: rtl/sim_exit_monitor.sv
// Simulation exit monitor: exit qualification, UART drain and watchdog.
// Optional SIM_EXIT_MONITOR_LOG_EN prints the result and ends the run.
module sim_exit_monitor
    import sim_exit_monitor_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000,
    parameter int unsigned STABLE_CYCLES  = 2,
    parameter int unsigned DRAIN_CYCLES   = 1000,
    parameter int unsigned CNT_W          = 64
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               enable_i,
    sim_exit_monitor_if.slave  exit_if,
    output logic               done_o,
    output logic               pass_o,
    output logic               timeout_o,
    output exit_code_t         exit_code_o,
    output logic [CNT_W-1:0]   cycle_cnt_o
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_DRAIN = DRAIN;
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0]       r_state;
    logic [31:0]      r_idle;
    logic [31:0]      r_drain;
    logic [CNT_W-1:0] r_cyc;
    exit_code_t       r_code;
    logic             r_done;
    logic             r_to;

    logic       w_run;
    logic       w_accept;
    exit_code_t w_acc_val;
    logic       w_wdog;

    assign w_run = (r_state == S_RUN);

    sim_exit_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .i_en     (w_run),
        .i_valid  (exit_if.exit_valid_i),
        .i_value  (exit_if.exit_value_i),
        .o_accept (w_accept),
        .o_value  (w_acc_val)
    );

    assign w_wdog = w_run
                 && (TIMEOUT_CYCLES != 32'd0)
                 && (r_idle == TIMEOUT_CYCLES - 32'd1)
                 && !exit_if.activity_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_idle  <= '0;
            r_drain <= '0;
            r_cyc   <= '0;
            r_code  <= '0;
            r_done  <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            unique case (1'b1)
                (r_state == S_IDLE): begin
                    if (enable_i) r_state <= S_RUN;
                end
                w_run: begin
                    if (r_cyc != '1) r_cyc <= r_cyc + CNT_W'(1);
                    r_idle <= exit_if.activity_i ? '0 : r_idle + 32'd1;
                    // An accept on the watchdog edge takes priority.
                    if (w_accept) begin
                        r_code  <= w_acc_val;
                        r_drain <= '0;
                        if (DRAIN_CYCLES == 0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else if (w_wdog) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_to    <= 1'b1;
                        r_code  <= TIMEOUT_CODE;
                    end
                end
                (r_state == S_DRAIN): begin
                    if (r_drain == 32'(DRAIN_CYCLES - 1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain + 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign done_o      = r_done;
    assign timeout_o   = r_to;
    assign exit_code_o = r_code;
    assign cycle_cnt_o = r_cyc;
    assign pass_o      = r_done && (r_code == '0) && !r_to;

`ifdef SIM_EXIT_MONITOR_LOG_EN
    logic r_done_q;
    logic r_fin;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_done_q <= 1'b0;
            r_fin    <= 1'b0;
        end else begin
            r_done_q <= r_done;
            r_fin    <= r_done && !r_done_q;
            if (r_done && !r_done_q)
                $display("[EXIT] %s code=%08h cycles=%0d",
                         r_to ? "TIMEOUT" : (pass_o ? "PASS" : "FAIL"),
                         r_code, r_cyc);
            if (r_fin) $finish;
        end
    end
`endif

endmodule

// File: tb/tb_sim_exit_monitor.sv
// Bench for sim_exit_monitor: directed table, corner sequences and
// randomized traces checked against an event-level reference model.
module tb_sim_exit_monitor;

    localparam int STAB = 2;
    localparam int DRN  = 4;
    localparam int TO   = 20;
    localparam int NC   = 70;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        done_o, pass_o, timeout_o;
    logic [31:0] code_o;
    logic [63:0] cyc_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic        tv   [NC];
    logic [31:0] tval [NC];
    logic        ta   [NC];

    sim_exit_monitor_if ex ();

    sim_exit_monitor #(
        .TIMEOUT_CYCLES (32'd20),
        .STABLE_CYCLES  (STAB),
        .DRAIN_CYCLES   (DRN),
        .CNT_W          (64)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .enable_i    (enable),
        .exit_if     (ex),
        .done_o      (done_o),
        .pass_o      (pass_o),
        .timeout_o   (timeout_o),
        .exit_code_o (code_o),
        .cycle_cnt_o (cyc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] v;
        logic [31:0] sel;
        logic [31:0] a;
        logic [31:0] val0;
        logic [31:0] val1;
        int          edge_n;
        logic        to;
        logic [31:0] code;
        logic [63:0] cyc;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] val,
                         input logic a);
        ex.exit_valid_i = v;
        ex.exit_value_i = val;
        ex.activity_i   = a;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b0;
        drive(1'b0, 32'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_run();
        @(negedge clk);
        enable = 1'b1;
        drive(1'b0, 32'd0, 1'b0);
        @(posedge clk);
        #1 enable = 1'b0;
    endtask

    // Applies the trace; returns the edge index (1-based after enable)
    // at which done_o was first seen, or 0.
    task automatic run_trace(output int done_edge);
        done_edge = 0;
        start_run();
        for (int j = 0; j < NC; j++) begin
            @(negedge clk);
            drive(tv[j], tval[j], ta[j]);
            @(posedge clk);
            #1;
            if (done_o && done_edge == 0) done_edge = j + 1;
        end
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b0);
    endtask

    // Event-level model: first stable window vs first silent window.
    task automatic model(output int e, output logic to,
                         output logic [31:0] code, output logic [63:0] cyc);
        int k = -1;
        int t = -1;
        for (int j = STAB - 1; j < NC && k < 0; j++) begin
            bit ok = 1;
            for (int i = 0; i < STAB; i++)
                if (!tv[j-i] || tval[j-i] != tval[j]) ok = 0;
            if (ok) k = j;
        end
        for (int j = TO - 1; j < NC && t < 0; j++) begin
            bit ok = 1;
            for (int i = 0; i < TO; i++)
                if (ta[j-i]) ok = 0;
            if (ok) t = j;
        end
        e = 0; to = 0; code = 0; cyc = 0;
        if (k >= 0 && (t < 0 || k <= t)) begin
            e = k + 1 + DRN; code = tval[k]; cyc = 64'(k + 1);
        end else if (t >= 0) begin
            e = t + 1; to = 1; code = 32'hFFFF_FFFF; cyc = 64'(t + 1);
        end
        if (e > NC) e = 0;
    endtask

    task automatic check_end(input string nm, input int got_e,
                             input int e, input logic to,
                             input logic [31:0] code, input logic [63:0] cyc);
        chk({nm, ".done_edge"}, 64'(got_e), 64'(e));
        if (e != 0) begin
            chk({nm, ".timeout"}, 64'(timeout_o), 64'(to));
            chk({nm, ".code"}, 64'(code_o), 64'(code));
            chk({nm, ".pass"}, 64'(pass_o), 64'(code == 0 && !to));
            chk({nm, ".cycles"}, cyc_o, cyc);
        end else begin
            chk({nm, ".not_done"}, 64'(done_o), 64'd0);
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, ".done"}, 64'(done_o), 64'd0);
        chk({nm, ".pass"}, 64'(pass_o), 64'd0);
        chk({nm, ".timeout"}, 64'(timeout_o), 64'd0);
        chk({nm, ".code"}, 64'(code_o), 64'd0);
        chk({nm, ".cycles"}, cyc_o, 64'd0);
    endtask

    initial begin
        int          ge, e;
        logic        m_to;
        logic [31:0] m_code;
        logic [63:0] m_cyc;

        tbl[0] = '{"pass", 32'h3, 32'h0, 32'h0, 32'h0, 32'h0,
                   6, 1'b0, 32'h0, 64'd2};
        tbl[1] = '{"failcode", 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h3, 32'h0,
                   6, 1'b0, 32'h3, 64'd2};
        tbl[2] = '{"glitch", 32'h1D, 32'h18, 32'h0, 32'h5, 32'h7,
                   9, 1'b0, 32'h7, 64'd5};
        tbl[3] = '{"watchdog", 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                   20, 1'b1, 32'hFFFF_FFFF, 64'd20};
        tbl[4] = '{"race", 32'hC_0000, 32'h0, 32'h0, 32'h2, 32'h0,
                   24, 1'b0, 32'h2, 64'd20};
        tbl[5] = '{"act_late", 32'h0, 32'h0, 32'h20, 32'h0, 32'h0,
                   26, 1'b1, 32'hFFFF_FFFF, 64'd26};
        tbl[6] = '{"change", 32'hF, 32'hE, 32'h0, 32'h1, 32'h2,
                   7, 1'b0, 32'h2, 64'd3};

        drive(1'b0, 32'd0, 1'b0);
        do_reset();
        #1 check_zero("reset");

        for (int n = 0; n < 7; n++) begin
            for (int j = 0; j < NC; j++) begin
                tv[j]   = (j < 32) ? tbl[n].v[j] : 1'b0;
                ta[j]   = (j < 32) ? tbl[n].a[j] : 1'b0;
                tval[j] = (j < 32 && tbl[n].sel[j]) ? tbl[n].val1
                                                    : tbl[n].val0;
            end
            do_reset();
            run_trace(ge);
            check_end(tbl[n].name, ge, tbl[n].edge_n, tbl[n].to,
                      tbl[n].code, tbl[n].cyc);
        end

        // Heartbeat every 10 cycles keeps the watchdog quiet.
        do_reset();
        start_run();
        for (int j = 0; j < 1000; j++) begin
            @(negedge clk);
            drive(1'b0, 32'd0, (j % 10) == 0);
            @(posedge clk);
        end
        #1;
        chk("heartbeat.done", 64'(done_o), 64'd0);
        chk("heartbeat.cycles", cyc_o, 64'd1000);
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b0);
        repeat (11) @(posedge clk);
        #1;
        chk("hb_stop.timeout", 64'(timeout_o), 64'd1);
        chk("hb_stop.cycles", cyc_o, 64'd1011);

        // Reset in the middle of DRAIN, then a clean re-run.
        do_reset();
        start_run();
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            drive(j < 2, 32'd3, 1'b0);
            @(posedge clk);
        end
        #1;
        chk("drain.code", 64'(code_o), 64'd3);
        chk("drain.done", 64'(done_o), 64'd0);
        chk("drain.cycles", cyc_o, 64'd2);
        do_reset();
        #1 check_zero("mid_reset");
        repeat (3) @(posedge clk);
        #1 chk("idle.cycles", cyc_o, 64'd0);
        for (int j = 0; j < NC; j++) begin
            tv[j] = (j < 2); tval[j] = 32'd0; ta[j] = 1'b0;
        end
        run_trace(ge);
        check_end("rerun", ge, 6, 1'b0, 32'd0, 64'd2);

        // Randomized traces against the model.
        for (int r = 0; r < 40; r++) begin
            int vr = $urandom_range(20, 90);
            int ar = (r % 3 == 0) ? 0 : ((r % 3 == 1) ? 4 : 25);
            for (int j = 0; j < NC; j++) begin
                tv[j] = ($urandom_range(0, 99) < vr);
                ta[j] = ($urandom_range(0, 99) < ar);
                case ($urandom_range(0, 2))
                    0: tval[j] = 32'd0;
                    1: tval[j] = 32'd9;
                    default: tval[j] = 32'h8000_0001;
                endcase
            end
            model(e, m_to, m_code, m_cyc);
            do_reset();
            run_trace(ge);
            check_end($sformatf("rand%0d", r), ge, e, m_to, m_code, m_cyc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
